rgb_lcd_ctrl: RTL and testbench

RGB_LCD_CTRL -- requirements
Module: rgb_lcd_ctrl

---
 rtl/rgb_lcd_ctrl_pkg.sv | 32 +++
 rtl/rgb_lcd_ctrl_sync_counter.sv | 61 ++++++
 rtl/rgb_lcd_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_rgb_lcd_ctrl.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rgb_lcd_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Package : rgb_pkg
// Purpose : Shared types and default timing constants for the RGB LCD
//           controller (FSM state encoding, default panel timing).
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
package rgb_pkg;

  // Controller power / scan state
  typedef enum logic [1:0] {
    ST_OFF    = 2'd0,
    ST_PWR_UP = 2'd1,
    ST_RUN    = 2'd2,
    ST_DRAIN  = 2'd3
  } state_t;

  // Default panel timing (clocks for horizontal, lines for vertical)
  localparam int unsigned DEF_H_ACTIVE   = 64;
  localparam int unsigned DEF_H_FP       = 8;
  localparam int unsigned DEF_H_SYNC     = 4;
  localparam int unsigned DEF_H_BP       = 8;
  localparam int unsigned DEF_V_ACTIVE   = 64;
  localparam int unsigned DEF_V_FP       = 2;
  localparam int unsigned DEF_V_SYNC     = 2;
  localparam int unsigned DEF_V_BP       = 2;
  localparam int unsigned DEF_COLOR_BITS = 8;
  localparam int unsigned DEF_DISP_DELAY = 16;

endpackage : rgb_pkg
`default_nettype wire

// File: rtl/rgb_lcd_ctrl_sync_counter.sv
`default_nettype none
// ============================================================================
// Module  : rgb_sync_counter
// Purpose : Wrapping scan counter (0..TOTAL-1) with sync-window decode.
//           Used once per axis (horizontal and vertical).
// Ports   : clk, reset      - clock, synchronous active-high reset
//           clr             - hold counter at zero (display not scanning)
//           inc             - advance counter by one (wraps after TOTAL-1)
//           cnt             - current count
//           wrap            - count is at its terminal value TOTAL-1
//           in_sync         - count lies in [SYNC_START, SYNC_START+SYNC_LEN)
// Rev     : 1.0  initial release
// ============================================================================
module rgb_sync_counter
  import rgb_pkg::*;
#(
  parameter int unsigned TOTAL      = 84,
  parameter int unsigned SYNC_START = 72,
  parameter int unsigned SYNC_LEN   = 4,
  parameter int unsigned CW         = $clog2(TOTAL)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          inc,
  output logic [CW-1:0] cnt,
  output logic          wrap,
  output logic          in_sync
);

  localparam logic [CW-1:0] LAST    = CW'(TOTAL - 1);
  // One extra bit so a window ending exactly at TOTAL cannot alias to zero
  localparam logic [CW:0]   SYNC_LO = (CW+1)'(SYNC_START);
  localparam logic [CW:0]   SYNC_HI = (CW+1)'(SYNC_START + SYNC_LEN);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign wrap    = (cnt_q == LAST);
  assign in_sync = ({1'b0, cnt_q} >= SYNC_LO) && ({1'b0, cnt_q} < SYNC_HI);
  assign cnt     = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = wrap ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule : rgb_sync_counter
`default_nettype wire

// File: rtl/rgb_lcd_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : rgb_lcd_ctrl
// Purpose : Parallel RGB LCD timing controller with power sequencing,
//           pixel-stream input and underflow detection.
// Ports   : clk, reset            - clock, synchronous active-high reset
//           enable                - start / keep display; low = stop at frame end
//           in_data/valid/ready   - pixel stream {R,G,B}, R in MSBs
//           underflow_clr         - clear sticky underflow flag
//           pix_x, pix_y          - coordinate of the pixel being requested
//           lcd_r/g/b, lcd_hsync, lcd_vsync, lcd_de, lcd_disp - panel pins
//           frame_start           - one-cycle pulse at the first frame pixel
//           underflow             - sticky: pixel requested but not supplied
//           busy                  - controller not in OFF
//           tp_en                 - (only with RGB_TEST_PATTERN_EN) selects the
//                                   internal 8-bar colour pattern
// Config  : `define RGB_TEST_PATTERN_EN to build the test-pattern generator.
// Rev     : 1.0  initial release
// ============================================================================
module rgb_lcd_ctrl
  import rgb_pkg::*;
#(
  parameter int unsigned H_ACTIVE   = DEF_H_ACTIVE,
  parameter int unsigned H_FP       = DEF_H_FP,
  parameter int unsigned H_SYNC     = DEF_H_SYNC,
  parameter int unsigned H_BP       = DEF_H_BP,
  parameter int unsigned V_ACTIVE   = DEF_V_ACTIVE,
  parameter int unsigned V_FP       = DEF_V_FP,
  parameter int unsigned V_SYNC     = DEF_V_SYNC,
  parameter int unsigned V_BP       = DEF_V_BP,
  parameter int unsigned COLOR_BITS = DEF_COLOR_BITS,
  parameter int unsigned DISP_DELAY = DEF_DISP_DELAY
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            enable,
  input  logic [3*COLOR_BITS-1:0]         in_data,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic                            underflow_clr,
`ifdef RGB_TEST_PATTERN_EN
  input  logic                            tp_en,
`endif
  output logic [$clog2(H_ACTIVE)-1:0]     pix_x,
  output logic [$clog2(V_ACTIVE)-1:0]     pix_y,
  output logic [COLOR_BITS-1:0]           lcd_r,
  output logic [COLOR_BITS-1:0]           lcd_g,
  output logic [COLOR_BITS-1:0]           lcd_b,
  output logic                            lcd_hsync,
  output logic                            lcd_vsync,
  output logic                            lcd_de,
  output logic                            lcd_disp,
  output logic                            frame_start,
  output logic                            underflow,
  output logic                            busy
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HCW     = $clog2(H_TOTAL);
  localparam int unsigned VCW     = $clog2(V_TOTAL);
  localparam int unsigned PXW     = $clog2(H_ACTIVE);
  localparam int unsigned PYW     = $clog2(V_ACTIVE);
  localparam int unsigned DCW     = (DISP_DELAY > 1) ? $clog2(DISP_DELAY) : 1;
  localparam logic [DCW-1:0] DLY_LAST = DCW'(DISP_DELAY - 1);
  localparam int unsigned PW      = 3 * COLOR_BITS;

  state_t         state_q, state_d;
  logic [DCW-1:0] dly_q, dly_d;
  logic           disp_q, de_q, hs_q, vs_q, fs_q, uf_q;
  logic           disp_d, de_d, hs_d, vs_d, fs_d, uf_d;
  logic [PW-1:0]  rgb_q, rgb_d;

  logic [HCW-1:0] h_cnt;
  logic [VCW-1:0] v_cnt;
  logic           h_wrap, v_wrap, h_sync, v_sync;
  logic           counting, active, frame_last, tp_on;

  assign counting   = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign frame_last = h_wrap && v_wrap;
  // Extra MSB keeps the compare correct when a porch total is zero
  assign active     = counting
                   && ({1'b0, h_cnt} < (HCW+1)'(H_ACTIVE))
                   && ({1'b0, v_cnt} < (VCW+1)'(V_ACTIVE));

  rgb_sync_counter #(
    .TOTAL      (H_TOTAL),
    .SYNC_START (H_ACTIVE + H_FP),
    .SYNC_LEN   (H_SYNC),
    .CW         (HCW)
  ) u_h_cnt (
    .clk     (clk),
    .reset   (reset),
    .clr     (!counting),
    .inc     (1'b1),
    .cnt     (h_cnt),
    .wrap    (h_wrap),
    .in_sync (h_sync)
  );

  rgb_sync_counter #(
    .TOTAL      (V_TOTAL),
    .SYNC_START (V_ACTIVE + V_FP),
    .SYNC_LEN   (V_SYNC),
    .CW         (VCW)
  ) u_v_cnt (
    .clk     (clk),
    .reset   (reset),
    .clr     (!counting),
    .inc     (h_wrap),
    .cnt     (v_cnt),
    .wrap    (v_wrap),
    .in_sync (v_sync)
  );

`ifdef RGB_TEST_PATTERN_EN
  logic [2:0]    tp_bar;
  logic [PW-1:0] tp_pix;
  assign tp_on  = tp_en;
  assign tp_bar = 3'((32'(pix_x) * 32'd8) / H_ACTIVE);
  assign tp_pix = {{COLOR_BITS{tp_bar[2]}}, {COLOR_BITS{tp_bar[1]}},
                   {COLOR_BITS{tp_bar[0]}}};
`else
  assign tp_on  = 1'b0;
`endif

  // The stream is not consulted while the internal pattern drives the panel
  assign in_ready = active && !tp_on;
  assign pix_x    = active ? h_cnt[PXW-1:0] : '0;
  assign pix_y    = active ? v_cnt[PYW-1:0] : '0;
  assign busy     = (state_q != ST_OFF);

  always_comb begin
    state_d = state_q;
    dly_d   = dly_q;
    case (state_q)
      ST_OFF: begin
        dly_d = '0;
        if (enable) state_d = ST_PWR_UP;
      end
      ST_PWR_UP: begin
        if (dly_q == DLY_LAST) begin
          state_d = ST_RUN;
          dly_d   = '0;
        end else begin
          dly_d = dly_q + DCW'(1);
        end
      end
      // A shutdown request on the very last cycle of a frame completes that
      // frame immediately instead of draining a whole further frame.
      ST_RUN: begin
        if (!enable) state_d = frame_last ? ST_OFF : ST_DRAIN;
      end
      ST_DRAIN: begin
        if (enable)          state_d = ST_RUN;
        else if (frame_last) state_d = ST_OFF;
      end
      default: state_d = ST_OFF;
    endcase

    disp_d = (state_d != ST_OFF);
    de_d   = active;
    hs_d   = !(counting && h_sync);
    vs_d   = !(counting && v_sync);
    fs_d   = counting && (h_cnt == '0) && (v_cnt == '0);
    rgb_d  = '0;
    if (in_ready && in_valid) rgb_d = in_data;
`ifdef RGB_TEST_PATTERN_EN
    if (active && tp_on) rgb_d = tp_pix;
`endif
    // Set has priority over clear
    uf_d = (in_ready && !in_valid) || (uf_q && !underflow_clr);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_OFF;
      dly_q   <= '0;
      disp_q  <= 1'b0;
      de_q    <= 1'b0;
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
      fs_q    <= 1'b0;
      uf_q    <= 1'b0;
      rgb_q   <= '0;
    end else begin
      state_q <= state_d;
      dly_q   <= dly_d;
      disp_q  <= disp_d;
      de_q    <= de_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      fs_q    <= fs_d;
      uf_q    <= uf_d;
      rgb_q   <= rgb_d;
    end
  end

  assign lcd_disp    = disp_q;
  assign lcd_de      = de_q;
  assign lcd_hsync   = hs_q;
  assign lcd_vsync   = vs_q;
  assign frame_start = fs_q;
  assign underflow   = uf_q;
  assign lcd_r       = rgb_q[3*COLOR_BITS-1:2*COLOR_BITS];
  assign lcd_g       = rgb_q[2*COLOR_BITS-1:COLOR_BITS];
  assign lcd_b       = rgb_q[COLOR_BITS-1:0];

endmodule : rgb_lcd_ctrl
`default_nettype wire

// File: tb/tb_rgb_lcd_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_rgb_lcd_ctrl
// Purpose : Self-checking bench for rgb_lcd_ctrl on a small panel
//           (H 4/1/1/1, V 3/1/1/1, DISP_DELAY 2).
// Rev     : 1.0  initial release
// ============================================================================
module tb_rgb_lcd_ctrl;

  localparam int HA = 4;
  localparam int HT = 7;
  localparam int VA = 3;
  localparam int VT = 6;
  localparam int DD = 2;
  localparam int HS = 5;   // hsync column
  localparam int VS = 4;   // vsync line

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        in_valid = 1'b0;
  logic        underflow_clr = 1'b0;
  logic [23:0] in_data = 24'h0;
  logic        in_ready;
  logic [1:0]  pix_x;
  logic [1:0]  pix_y;
  logic [7:0]  lcd_r, lcd_g, lcd_b;
  logic        lcd_hsync, lcd_vsync, lcd_de, lcd_disp;
  logic        frame_start, underflow, busy;

  always #5 clk = ~clk;

  rgb_lcd_ctrl #(
    .H_ACTIVE(HA), .H_FP(1), .H_SYNC(1), .H_BP(1),
    .V_ACTIVE(VA), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .COLOR_BITS(8), .DISP_DELAY(DD)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .underflow_clr(underflow_clr), .pix_x(pix_x), .pix_y(pix_y),
    .lcd_r(lcd_r), .lcd_g(lcd_g), .lcd_b(lcd_b),
    .lcd_hsync(lcd_hsync), .lcd_vsync(lcd_vsync), .lcd_de(lcd_de),
    .lcd_disp(lcd_disp), .frame_start(frame_start),
    .underflow(underflow), .busy(busy)
  );

  typedef struct packed {
    logic        disp, de, hs, vs, fs, uf;
    logic [23:0] rgb;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;

  // Reference model state: 0 OFF, 1 PWR_UP, 2 RUN, 3 DRAIN
  int   m_st = 0, m_h = 0, m_v = 0, m_dly = 0;
  logic m_uf = 1'b0;

  int   disp_rise = 0, last_fs = 0;
  bit   fs_seen = 0;
  logic prev_disp = 1'b0;
  int   de_cnt = 0, red_cnt = 0, hs_cnt = 0, vs_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock: check combinational outputs, push expected registered
  // outputs, clock, then pop and compare.
  task automatic step();
    bit   cnt, ready, last;
    int   nst, nh, nv, ndly;
    logic nuf;
    exp_t e, o;

    cnt   = (m_st == 2) || (m_st == 3);
    ready = cnt && (m_h < HA) && (m_v < VA);
    last  = (m_h == HT-1) && (m_v == VT-1);
    check("in_ready", in_ready, ready);
    check("busy", busy, m_st != 0);
    if (ready) begin
      check("pix_x", pix_x, m_h);
      check("pix_y", pix_y, m_v);
    end

    nst = m_st;
    ndly = m_dly;
    case (m_st)
      0: begin ndly = 0; if (enable) nst = 1; end
      1: if (m_dly == DD-1) begin nst = 2; ndly = 0; end else ndly = m_dly + 1;
      2: if (!enable) nst = last ? 0 : 3;
      3: if (enable) nst = 2; else if (last) nst = 0;
      default: nst = 0;
    endcase
    if (cnt) begin
      nh = (m_h == HT-1) ? 0 : m_h + 1;
      nv = (m_h == HT-1) ? ((m_v == VT-1) ? 0 : m_v + 1) : m_v;
    end else begin
      nh = 0;
      nv = 0;
    end
    nuf = (ready && !in_valid) ? 1'b1 : (underflow_clr ? 1'b0 : m_uf);

    e.disp = (nst != 0);
    e.de   = ready;
    e.hs   = !(cnt && m_h == HS);
    e.vs   = !(cnt && m_v == VS);
    e.fs   = cnt && m_h == 0 && m_v == 0;
    e.uf   = nuf;
    e.rgb  = (ready && in_valid) ? in_data : 24'h0;
    if (reset) begin
      nst = 0; nh = 0; nv = 0; ndly = 0; nuf = 1'b0;
      e = '0;
      e.hs = 1'b1;
      e.vs = 1'b1;
    end
    sb.push_back(e);

    @(posedge clk);
    #1;
    cyc++;
    o = sb.pop_front();
    check("lcd_disp", lcd_disp, o.disp);
    check("lcd_de", lcd_de, o.de);
    check("lcd_hsync", lcd_hsync, o.hs);
    check("lcd_vsync", lcd_vsync, o.vs);
    check("frame_start", frame_start, o.fs);
    check("underflow", underflow, o.uf);
    check("lcd_rgb", {lcd_r, lcd_g, lcd_b}, o.rgb);

    if (lcd_disp && !prev_disp) begin
      disp_rise = cyc;
      fs_seen   = 0;
    end
    if (frame_start) begin
      if (!fs_seen) check("disp_to_fs", cyc - disp_rise, 3);
      else          check("fs_period", cyc - last_fs, HT*VT);
      fs_seen = 1;
      last_fs = cyc;
    end
    prev_disp = lcd_disp;
    if (lcd_de) de_cnt++;
    if (lcd_de && lcd_r == 8'hFF) red_cnt++;
    if (!lcd_hsync) hs_cnt++;
    if (!lcd_vsync) vs_cnt++;

    m_st = nst; m_h = nh; m_v = nv; m_dly = ndly; m_uf = nuf;
  endtask

  initial begin
    bit hit;

    // Reset, then power up with a solid red stream
    in_valid = 1'b1;
    in_data  = 24'hFF0000;
    repeat (3) step();
    reset  = 1'b0;
    enable = 1'b1;
    repeat (60) step();
    de_cnt = 0; red_cnt = 0; hs_cnt = 0; vs_cnt = 0;
    repeat (HT*VT) step();
    check("de_per_frame", de_cnt, HA*VA);
    check("red_per_frame", red_cnt, HA*VA);
    check("hsync_low_per_frame", hs_cnt, VT);
    check("vsync_low_per_frame", vs_cnt, HT);
    check("no_underflow", underflow, 0);

    // Withhold the pixel at (2,1)
    hit = 0;
    for (int i = 0; i < 100 && !hit; i++) begin
      in_valid = !(in_ready && pix_x == 2'd2 && pix_y == 2'd1);
      if (!in_valid) hit = 1;
      step();
    end
    in_valid = 1'b1;
    check("uf_target_reached", hit, 1);
    repeat (10) step();
    underflow_clr = 1'b1;
    step();
    underflow_clr = 1'b0;
    repeat (5) step();

    // Simultaneous set and clear
    hit = 0;
    for (int i = 0; i < 100 && !hit; i++) begin
      if (in_ready) begin
        in_valid = 1'b0;
        underflow_clr = 1'b1;
        hit = 1;
      end
      step();
      in_valid = 1'b1;
      underflow_clr = 1'b0;
    end
    check("set_clr_reached", hit, 1);
    repeat (3) step();

    // Random pixels, gaps and clears
    for (int i = 0; i < 2*HT*VT; i++) begin
      in_data       = 24'($urandom);
      in_valid      = ($urandom_range(0, 3) != 0);
      underflow_clr = ($urandom_range(0, 7) == 0);
      step();
    end
    in_valid = 1'b1;
    in_data  = 24'hFF0000;
    underflow_clr = 1'b1;
    step();
    underflow_clr = 1'b0;

    // Short shutdown request cancelled during drain: no frame gap
    for (int i = 0; i < 100 && !(m_h == 3 && m_v == 2); i++) step();
    enable = 1'b0;
    repeat (5) step();
    enable = 1'b1;
    repeat (60) step();

    // Shutdown mid-frame: frame completes, then OFF
    for (int i = 0; i < 100 && !(m_h == 2 && m_v == 1); i++) step();
    enable = 1'b0;
    for (int i = 0; i < 100 && busy; i++) step();
    check("drain_done_busy", busy, 0);
    check("drain_done_disp", lcd_disp, 0);
    repeat (4) step();

    // Power up again, reset at v_cnt=2
    enable = 1'b1;
    hit = 0;
    for (int i = 0; i < 100 && !hit; i++) begin
      if (m_st == 2 && m_v == 2 && m_h == 1) hit = 1;
      else step();
    end
    check("reset_point_reached", hit, 1);
    reset = 1'b1;
    step();
    check("reset_in_ready", in_ready, 0);
    check("reset_busy", busy, 0);
    reset  = 1'b0;
    enable = 1'b0;
    repeat (4) step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_rgb_lcd_ctrl
`default_nettype wire
